// File: rtl/match_referee.sv
// match_referee -- round/match arbiter for the two-player snake game.
//
// Watches the two snake crash flags, awards rounds, detects the match winner,
// freezes the snakes between rounds, and drives a 4-digit multiplexed
// 7-segment scoreboard.
//
// Ports:
//   clk            system clock (100 MHz)
//   rst            synchronous active-high reset
//   hit_flag_1     level, snake 1 crashed (point to player 2)
//   hit_flag_2     level, snake 2 crashed (point to player 1)
//   start          one-cycle pulse, begins / re-begins a match
//   over           level, snakes frozen while high
//   round_restart  one-cycle pulse, snakes reinitialise
//   winner         00 none, 01 P1, 10 P2, 11 draw
//   score_1        player-1 round wins
//   score_2        player-2 round wins
//   sel            digit enables, active-low, sel[3] leftmost
//   seg            segments, active-low, seg[7]=dp, seg[6:0]=g..a
module match_referee #(
    parameter int WIN_SCORE   = 5,
    parameter int HOLD_CYCLES = 200_000_000,
    parameter int SCAN_DIV    = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit_flag_1,
    input  logic       hit_flag_2,
    input  logic       start,
    output logic       over,
    output logic       round_restart,
    output logic [1:0] winner,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [3:0] sel,
    output logic [7:0] seg
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_P    = 8'h8C;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        ROUND_END = 2'd2,
        MATCH_END = 2'd3
    } state_t;

    state_t state, state_n;

    logic       over_n, rr_n;
    logic [1:0] winner_n;
    logic [3:0] score_1_n, score_2_n;

    logic          hit_1_d, hit_2_d;
    logic          e1, e2;
    logic [HW-1:0] hold_cnt;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx, idx_n;
    logic [3:0]    sel_n;
    logic [7:0]    seg_n;

    // Rising edges only: a flag that is still high from the previous round
    // (or high before PLAY was entered) must not score again.
    assign e1 = hit_flag_1 & ~hit_1_d;
    assign e2 = hit_flag_2 & ~hit_2_d;

    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // ---------------- game FSM ----------------
    always_comb begin
        state_n   = state;
        over_n    = over;
        rr_n      = 1'b0;
        winner_n  = winner;
        score_1_n = score_1;
        score_2_n = score_2;
        case (state)
            IDLE, MATCH_END: begin
                over_n = 1'b1;
                if (start) begin
                    state_n   = PLAY;
                    rr_n      = 1'b1;
                    over_n    = 1'b0;
                    winner_n  = 2'b00;
                    score_1_n = 4'd0;
                    score_2_n = 4'd0;
                end
            end
            PLAY: begin
                over_n = 1'b0;
                if (e1 | e2) begin
                    over_n  = 1'b1;
                    state_n = ROUND_END;
                    if (e1 & e2) begin
                        winner_n = 2'b11;
                    end else if (e1) begin
                        winner_n  = 2'b10;
                        score_2_n = score_2 + 4'd1;
                        if (score_2_n == WIN) state_n = MATCH_END;
                    end else begin
                        winner_n  = 2'b01;
                        score_1_n = score_1 + 4'd1;
                        if (score_1_n == WIN) state_n = MATCH_END;
                    end
                end
            end
            ROUND_END: begin
                over_n = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_n  = PLAY;
                    rr_n     = 1'b1;
                    over_n   = 1'b0;
                    winner_n = 2'b00;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            over          <= 1'b1;
            round_restart <= 1'b0;
            winner        <= 2'b00;
            score_1       <= 4'd0;
            score_2       <= 4'd0;
            hit_1_d       <= 1'b0;
            hit_2_d       <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            state         <= state_n;
            over          <= over_n;
            round_restart <= rr_n;
            winner        <= winner_n;
            score_1       <= score_1_n;
            score_2       <= score_2_n;
            hit_1_d       <= hit_flag_1;
            hit_2_d       <= hit_flag_2;
            // Zero outside ROUND_END so every hold starts from 0 on entry.
            hold_cnt      <= (state == ROUND_END) ? hold_cnt + 1'b1 : '0;
        end
    end

    // ---------------- scoreboard scanner ----------------
    // sel/seg are computed from the next digit index so both change on the
    // same edge as the index itself.
    always_comb begin
        idx_n = (scan_cnt == SCAN_LAST) ? idx + 2'd1 : idx;
        sel_n = ~(4'b0001 << idx_n);
        seg_n = SEG_DASH;
        case (idx_n)
            2'd3: seg_n = digit_seg(score_1);
            2'd2: seg_n = (state == MATCH_END) ? SEG_P : SEG_DASH;
            2'd1: begin
                if (state == MATCH_END)
                    seg_n = (winner == 2'b01) ? digit_seg(4'd1) :
                            (winner == 2'b10) ? digit_seg(4'd2) : SEG_DASH;
            end
            default: seg_n = digit_seg(score_2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            sel      <= 4'b1110;
            seg      <= 8'hC0;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
            idx      <= idx_n;
            sel      <= sel_n;
            seg      <= seg_n;
        end
    end

endmodule

// File: tb/tb_match_referee.sv
// Self-checking bench for match_referee (WIN_SCORE=2, HOLD_CYCLES=8, SCAN_DIV=4).
// A behavioural game model runs alongside the DUT and is compared every cycle;
// directed steps add literal expectations.
module tb_match_referee;

    localparam int WIN  = 2;
    localparam int HOLD = 8;
    localparam int SDIV = 4;

    logic       clk = 1'b0;
    logic       rst, hit_flag_1, hit_flag_2, start;
    logic       over, round_restart;
    logic [1:0] winner;
    logic [3:0] score_1, score_2, sel;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;

    match_referee #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .hit_flag_1(hit_flag_1), .hit_flag_2(hit_flag_2),
        .start(start), .over(over), .round_restart(round_restart),
        .winner(winner), .score_1(score_1), .score_2(score_2),
        .sel(sel), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 playing, 2 between rounds, 3 match decided
    logic [7:0] dig_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    bit         m_valid = 0;
    int         m_phase, m_hold, m_s1, m_s2, m_win, m_k;
    bit         m_over, m_rr, m_p1, m_p2;
    logic [3:0] m_sel;
    logic [7:0] m_seg;

    always @(posedge clk) begin
        bit e1, e2;
        int d;
        if (rst) begin
            m_valid = 1; m_phase = 0; m_over = 1; m_rr = 0; m_win = 0;
            m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0; m_k = 0; m_hold = 0;
            m_sel = 4'hE; m_seg = 8'hC0;
        end else if (m_valid) begin
            e1 = hit_flag_1 && !m_p1;
            e2 = hit_flag_2 && !m_p2;
            // display reflects the game state as it was before this edge
            m_k++;
            d = (m_k / SDIV) % 4;
            m_sel = 4'hF;
            m_sel[d] = 1'b0;
            case (d)
                3: m_seg = dig_tab[m_s1];
                2: m_seg = (m_phase == 3) ? 8'h8C : 8'hBF;
                1: m_seg = (m_phase == 3) ? dig_tab[m_win] : 8'hBF;
                default: m_seg = dig_tab[m_s2];
            endcase
            m_rr = 0;
            case (m_phase)
                0, 3: if (start) begin
                    m_phase = 1; m_rr = 1; m_over = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
                end
                1: if (e1 || e2) begin
                    m_over = 1; m_hold = HOLD; m_phase = 2;
                    if (e1 && e2) m_win = 3;
                    else if (e1) begin m_s2++; m_win = 2; if (m_s2 == WIN) m_phase = 3; end
                    else begin m_s1++; m_win = 1; if (m_s1 == WIN) m_phase = 3; end
                end
                default: begin
                    m_hold--;
                    if (m_hold == 0) begin m_phase = 1; m_rr = 1; m_win = 0; m_over = 0; end
                end
            endcase
            m_p1 = hit_flag_1;
            m_p2 = hit_flag_2;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("over", 32'(over), 32'(m_over));
            chk("round_restart", 32'(round_restart), 32'(m_rr));
            chk("winner", 32'(winner), 32'(m_win));
            chk("score_1", 32'(score_1), 32'(m_s1));
            chk("score_2", 32'(score_2), 32'(m_s2));
            chk("sel", 32'(sel), 32'(m_sel));
            chk("seg", 32'(seg), 32'(m_seg));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] disp [4];
    int         sel_hits [4];

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Sample 16 cycles and sort segment patterns by the digit they light.
    task automatic grab_display();
        for (int i = 0; i < 4; i++) sel_hits[i] = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            case (sel)
                4'b1110: begin disp[0] = seg; sel_hits[0]++; end
                4'b1101: begin disp[1] = seg; sel_hits[1]++; end
                4'b1011: begin disp[2] = seg; sel_hits[2]++; end
                4'b0111: begin disp[3] = seg; sel_hits[3]++; end
                default: chk("sel_onehot", 32'(sel), 32'hE);
            endcase
        end
    endtask

    initial begin
        rst = 1; hit_flag_1 = 0; hit_flag_2 = 0; start = 0;
        tick(2);
        chk("rst_over", 32'(over), 1);
        chk("rst_sel", 32'(sel), 32'hE);
        chk("rst_seg", 32'(seg), 32'hC0);
        rst = 0;

        // idle scan: each digit held 4 cycles, dash in the middle
        grab_display();
        for (int i = 0; i < 4; i++) chk("idle_sel_hold", 32'(sel_hits[i]), 4);
        chk("idle_d0", 32'(disp[0]), 32'hC0);
        chk("idle_d1", 32'(disp[1]), 32'hBF);
        chk("idle_d2", 32'(disp[2]), 32'hBF);
        chk("idle_d3", 32'(disp[3]), 32'hC0);

        // start a match
        start = 1; tick(); start = 0;
        chk("start_rr", 32'(round_restart), 1);
        chk("start_over", 32'(over), 0);
        tick();
        chk("start_rr_single", 32'(round_restart), 0);

        // snake 2 crashes and stays crashed: point to P1
        hit_flag_2 = 1; tick();
        chk("p1_over", 32'(over), 1);
        chk("p1_winner", 32'(winner), 1);
        chk("p1_score", 32'(score_1), 1);
        tick(HOLD - 1);
        chk("hold_no_rr", 32'(round_restart), 0);
        tick();
        chk("hold_rr", 32'(round_restart), 1);
        chk("hold_over", 32'(over), 0);
        chk("hold_winner", 32'(winner), 0);
        tick(3);
        chk("stuck_flag_no_point", 32'(score_1), 1);
        hit_flag_2 = 0; tick();

        // simultaneous crash: draw
        hit_flag_1 = 1; hit_flag_2 = 1; tick();
        hit_flag_1 = 0; hit_flag_2 = 0;
        chk("draw_winner", 32'(winner), 3);
        chk("draw_s1", 32'(score_1), 1);
        chk("draw_s2", 32'(score_2), 0);

        // reset in the middle of the hold
        tick(3);
        rst = 1; tick(); rst = 0;
        chk("midrst_over", 32'(over), 1);
        chk("midrst_rr", 32'(round_restart), 0);
        chk("midrst_s1", 32'(score_1), 0);
        for (int i = 0; i < HOLD + 4; i++) begin
            tick();
            chk("midrst_stay_idle", 32'({over, round_restart}), 32'b10);
        end

        // fresh match, two P2 wins
        start = 1; tick(); start = 0;
        chk("restart_rr", 32'(round_restart), 1);
        tick(2);
        hit_flag_1 = 1; tick(); hit_flag_1 = 0;
        chk("p2_r1_score", 32'(score_2), 1);
        chk("p2_r1_winner", 32'(winner), 2);
        tick(HOLD + 2);
        hit_flag_1 = 1; tick(); hit_flag_1 = 0;
        chk("p2_match_score", 32'(score_2), 2);
        chk("p2_match_winner", 32'(winner), 2);
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("match_over_held", 32'(over), 1);
        end
        grab_display();
        chk("match_d3", 32'(disp[3]), 32'hC0);
        chk("match_d2", 32'(disp[2]), 32'h8C);
        chk("match_d1", 32'(disp[1]), 32'hA4);
        chk("match_d0", 32'(disp[0]), 32'hA4);

        // start from the decided match
        start = 1; tick(); start = 0;
        chk("rematch_rr", 32'(round_restart), 1);
        chk("rematch_s2", 32'(score_2), 0);
        chk("rematch_winner", 32'(winner), 0);
        chk("rematch_over", 32'(over), 0);
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
